// File: rtl/normal_pkg.sv
// Shared types and width helpers for the normal multiply / divide datapaths.
package normal_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Dividend/quotient width for a given operand width: 2*DATA_W+1.
    function automatic int unsigned qw_of(input int unsigned dw);
        return 2 * dw + 1;
    endfunction

    function automatic int unsigned cnt_w_of(input int unsigned dw);
        return $clog2(2 * dw + 1);
    endfunction

    // Quotient reported on divide-by-zero; sliced to QW at the use site.
    localparam logic [63:0] DBZ_Q = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
module div_step #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W:0]   rem,
    input  logic              din,
    input  logic [DATA_W-1:0] c,
    output logic [DATA_W:0]   rem_next,
    output logic              qbit
);

    logic [DATA_W+1:0] shifted;
    logic [DATA_W+1:0] diff;

    always_comb begin
        shifted  = {rem, din};
        diff     = shifted - {2'b00, c};
        // Borrow out of the extra top bit means the trial subtraction went negative.
        qbit     = ~diff[DATA_W+1];
        rem_next = qbit ? diff[DATA_W:0] : shifted[DATA_W:0];
    end

endmodule

// File: rtl/normal_div.sv
// Sequential restoring divider recovering (a+b) and remainder from y = (a+b)*c, one bit per clock.
module normal_div
    import normal_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DATA_W:0]   y,
    input  logic [DATA_W-1:0]   c,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W:0]   q,
    output logic [DATA_W-1:0]   r,
    output logic                dbz
);

    localparam int unsigned QW = qw_of(DATA_W);
    localparam int unsigned CW = cnt_w_of(DATA_W);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [QW-1:0]     sreg;
    logic [DATA_W:0]   rem;
    logic [DATA_W-1:0] div_c;
    logic [DATA_W:0]   rem_next;
    logic              qbit;

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem      (rem),
        .din      (sreg[QW-1]),
        .c        (div_c),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    // sreg shifts dividend bits out of the top while quotient bits enter at the bottom,
    // so after QW iterations it holds the full quotient.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            dbz       <= 1'b0;
            cnt       <= '0;
            sreg      <= '0;
            rem       <= '0;
            div_c     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg     <= y;
                        div_c    <= c;
                        rem      <= '0;
                        cnt      <= CW'(QW - 1);
                        in_ready <= 1'b0;
                        if (c == '0) begin
                            state     <= DONE;
                            q         <= DBZ_Q[QW-1:0];
                            r         <= '0;
                            dbz       <= 1'b1;
                            out_valid <= 1'b1;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    sreg <= {sreg[QW-2:0], qbit};
                    rem  <= rem_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state     <= DONE;
                        q         <= {sreg[QW-2:0], qbit};
                        r         <= rem_next[DATA_W-1:0];
                        dbz       <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_normal_div.sv
// Directed self-checking bench for normal_div (DATA_W=8, QW=17).
module tb_normal_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] y;
    logic [7:0]  c;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] q;
    logic [7:0]  r;
    logic        dbz;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int          lat;

    normal_div #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present y/c for exactly one edge; DUT must be idle so the edge accepts.
    task automatic start(input logic [16:0] yy, input logic [7:0] cc);
        y        = yy;
        c        = cc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Edges after the accept edge until out_valid is seen; 0 means up right after accept.
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        y         = '0;
        c         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        chk("rst_dbz", dbz, 0);
        rst = 1'b0;

        // 130050 = 510*255
        start(17'd130050, 8'd255);
        chk("t1_busy_in_ready", in_ready, 0);
        chk("t1_busy_out_valid", out_valid, 0);
        wait_done(lat);
        chk("t1_latency", lat, 17);
        chk("t1_q", q, 510);
        chk("t1_r", r, 0);
        chk("t1_dbz", dbz, 0);
        handshake();
        chk("t1_hs_out_valid", out_valid, 0);
        chk("t1_hs_in_ready", in_ready, 1);

        // 1000 = 7*142 + 6
        start(17'd1000, 8'd7);
        wait_done(lat);
        chk("t2_latency", lat, 17);
        chk("t2_q", q, 142);
        chk("t2_r", r, 6);
        handshake();

        start(17'd0, 8'd5);
        wait_done(lat);
        chk("t3_q", q, 0);
        chk("t3_r", r, 0);
        chk("t3_dbz", dbz, 0);
        handshake();

        start(17'd131071, 8'd1);
        wait_done(lat);
        chk("t4_q", q, 131071);
        chk("t4_r", r, 0);
        handshake();

        // Divide by zero: result is up in the cycle right after the accept edge.
        start(17'd100, 8'd0);
        chk("t5_latency_out_valid", out_valid, 1);
        chk("t5_q", q, 17'h1FFFF);
        chk("t5_r", r, 0);
        chk("t5_dbz", dbz, 1);
        handshake();
        chk("t5_hs_in_ready", in_ready, 1);

        // Stall in DONE while a new request is pending; it must not disturb the result.
        start(17'd1000, 8'd7);
        wait_done(lat);
        chk("t6_q", q, 142);
        y        = 17'd50;
        c        = 8'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("t6_stall_q", q, 142);
            chk("t6_stall_r", r, 6);
            chk("t6_stall_in_ready", in_ready, 0);
            chk("t6_stall_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("t6_hs_out_valid", out_valid, 0);
        chk("t6_hs_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t6_next_accept", in_ready, 0);
        wait_done(lat);
        chk("t6_next_latency", lat, 17);
        chk("t6_next_q", q, 16);
        chk("t6_next_r", r, 2);
        handshake();

        // Reset during the 8th BUSY cycle discards the pending result.
        start(17'd1000, 8'd7);
        repeat (7) @(posedge clk);
        #1;
        chk("t7_busy_in_ready", in_ready, 0);
        chk("t7_busy_out_valid", out_valid, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t7_rst_out_valid", out_valid, 0);
        chk("t7_rst_in_ready", in_ready, 1);
        chk("t7_rst_q", q, 0);
        chk("t7_rst_r", r, 0);
        repeat (20) @(posedge clk);
        #1;
        chk("t7_discarded", out_valid, 0);
        start(17'd130050, 8'd255);
        wait_done(lat);
        chk("t7_fresh_latency", lat, 17);
        chk("t7_fresh_q", q, 510);
        chk("t7_fresh_r", r, 0);
        handshake();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
